pwm_cmd_decoder: RTL and testbench
==================================

PWM_CMD_DECODER -- requirements
Module: pwm_cmd_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter STROBE_CYCLES, default 2, high time of each WE strobe in Clock cycles, legal range 1..15.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum inter-byte gap inside a frame, legal range 2..65535.
REQ-004 Clock  input  1  system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_ready  output  1  decoder accepts a byte this cycle.
REQ-009 period_low, period_high, impuls_low, impuls_high  output  8 each  data buses to the PWM stage.
REQ-010 WE_period_low, WE_period_high, WE_impuls_low, WE_impuls_high  output  1 each  write strobes; the PWM stage latches on the falling edge.
REQ-011 WE_enable_pwm, WE_disable_pwm  output  1 each  enable/disable strobes.
REQ-012 frame_ok, frame_err  output  1 each  one-cycle status pulses.

Function
REQ-013 A byte SHALL be accepted only on a rising edge with rx_valid=1 and rx_ready=1.
REQ-014 Frame format SHALL be: SYNC_BYTE, CMD, DATA_LO, DATA_HI, CHK, where CHK = CMD ^ DATA_LO ^ DATA_HI.
REQ-015 FSM states SHALL be IDLE, GET_CMD, GET_LO, GET_HI, GET_CHK, STROBE, GAP.
REQ-016 In IDLE, an accepted byte equal to SYNC_BYTE SHALL move to GET_CMD; any other byte SHALL be discarded silently.
REQ-017 GET_CMD, GET_LO, GET_HI and GET_CHK SHALL each capture one accepted byte and advance to the next state in that order.
REQ-018 In GET_CHK, a CHK mismatch or an unknown CMD SHALL pulse frame_err and return to IDLE, with no output bus or strobe change.
REQ-019 Valid CMD values SHALL be 0x01 (set period), 0x02 (set impuls), 0x03 (enable), 0x04 (disable); other CMD values are invalid.
REQ-020 On a good frame, the decoder SHALL enter STROBE and pulse frame_ok in the cycle of entry.
REQ-021 For 0x01 and 0x02, the decoder SHALL load the target low/high buses one cycle before either strobe rises, and hold them stable until after the strobe falls.
REQ-022 For 0x01 and 0x02, the low and high WE strobes of the target SHALL be high together for exactly STROBE_CYCLES cycles.
REQ-023 For 0x03 and 0x04, the corresponding enable/disable strobe SHALL be high for STROBE_CYCLES cycles; data buses SHALL not change.
REQ-024 After the strobe falls, the decoder SHALL spend one GAP cycle, then return to IDLE.
REQ-025 rx_ready SHALL be 1 in IDLE and GET_* states, and 0 in STROBE and GAP.
REQ-026 At most one strobe group SHALL be high at any time; WE_enable_pwm and WE_disable_pwm SHALL never be high together.
REQ-027 Output buses SHALL hold their last written values indefinitely; period and impuls buses are independent.
REQ-028 A 16-bit gap counter SHALL clear on every accepted byte.
REQ-029 While in a GET_* state, the gap counter SHALL increment each cycle without an accepted byte.
REQ-030 When the gap counter reaches TIMEOUT_CYCLES, the decoder SHALL pulse frame_err and return to IDLE.
REQ-031 SYNC_BYTE received in any GET_* state SHALL be treated as ordinary data, not as a resync.

Reset
REQ-032 While Reset=0, the FSM SHALL be in IDLE.
REQ-033 While Reset=0, all data buses SHALL be 8'h00.
REQ-034 While Reset=0, all strobes, frame_ok, frame_err and the gap counter SHALL be 0.
REQ-035 While Reset=0, rx_ready SHALL be 0; after release, rx_ready SHALL be 1 from the first rising edge.
REQ-036 Reset asserted mid-frame or mid-strobe SHALL drop all strobes immediately and discard the partial frame.

Structure
REQ-037 Command codes, the default SYNC_BYTE and the state encoding SHALL live in shared package pwm_pkg, also used by future PWM-side blocks.
REQ-038 The strobe/gap timing SHALL be a sub-module pwm_strobe_gen (inputs: start, group select; outputs: the six strobes, busy).
REQ-039 The FSM and frame parser SHALL stay in the top module.

Verification
REQ-040 Bytes A5 01 E8 03 EA, back-to-back -> period_low=E8, period_high=03; WE_period_low and WE_period_high high for 2 cycles; frame_ok pulses once.
REQ-041 Bytes A5 02 F4 01 F7 -> impuls buses = F4/01; period buses unchanged from previous values.
REQ-042 Bytes A5 01 10 00 00 (bad CHK) -> frame_err pulse; no strobe; buses unchanged; a following good frame is accepted.
REQ-043 Bytes 33 A5 03 00 00 03 -> 33 ignored; WE_enable_pwm high for 2 cycles; rx_valid held high throughout shows rx_ready=0 for 3 cycles.
REQ-044 Bytes A5 04, then 1000 idle cycles -> frame_err at the timeout; a new frame then completes normally.
REQ-045 Reset pulsed during the STROBE state of a set-period frame -> strobes drop asynchronously; buses read 00; FSM in IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: frame marker, command codes, decoder states and strobe groups.
// Future PWM-side blocks import this so command encodings stay in one place.
package pwm_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_SET_PERIOD = 8'h01;
    localparam logic [7:0] CMD_SET_IMPULS = 8'h02;
    localparam logic [7:0] CMD_ENABLE     = 8'h03;
    localparam logic [7:0] CMD_DISABLE    = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_LO,
        ST_GET_HI,
        ST_GET_CHK,
        ST_STROBE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        GRP_PERIOD,
        GRP_IMPULS,
        GRP_ENABLE,
        GRP_DISABLE
    } strobe_grp_t;

    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return (cmd == CMD_SET_PERIOD) || (cmd == CMD_SET_IMPULS) ||
               (cmd == CMD_ENABLE)     || (cmd == CMD_DISABLE);
    endfunction

    function automatic strobe_grp_t cmd_to_grp(input logic [7:0] cmd);
        case (cmd)
            CMD_SET_IMPULS: return GRP_IMPULS;
            CMD_ENABLE:     return GRP_ENABLE;
            CMD_DISABLE:    return GRP_DISABLE;
            default:        return GRP_PERIOD;
        endcase
    endfunction

endpackage

// File: rtl/pwm_cmd_decoder_if.sv
// Byte-stream handshake into the PWM command decoder.
// A byte transfers on a rising Clock edge with rx_valid and rx_ready both high.
interface pwm_cmd_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/pwm_strobe_gen.sv
// Write-strobe timing for the PWM stage: optional one-cycle bus setup, then a
// STROBE_CYCLES-long pulse on exactly one strobe group.
module pwm_strobe_gen
    import pwm_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start_i,
    input  strobe_grp_t grp_i,
    output logic        WE_period_low,
    output logic        WE_period_high,
    output logic        WE_impuls_low,
    output logic        WE_impuls_high,
    output logic        WE_enable_pwm,
    output logic        WE_disable_pwm,
    output logic        busy_o
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    strobe_grp_t grp_q, grp_d;
    logic        setup_q, setup_d;
    logic        act_q, act_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  we_q, we_d;

    function automatic logic [5:0] grp_mask(input strobe_grp_t g);
        case (g)
            GRP_PERIOD: return 6'b000011;
            GRP_IMPULS: return 6'b001100;
            GRP_ENABLE: return 6'b010000;
            default:    return 6'b100000;
        endcase
    endfunction

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            grp_q   <= GRP_PERIOD;
            setup_q <= 1'b0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            we_q    <= '0;
        end else begin
            grp_q   <= grp_d;
            setup_q <= setup_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

    // Data groups wait one cycle so the freshly loaded buses settle before WE rises.
    always_comb begin
        grp_d   = grp_q;
        setup_d = setup_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            grp_d = grp_i;
            if (grp_i == GRP_PERIOD || grp_i == GRP_IMPULS) begin
                setup_d = 1'b1;
            end else begin
                act_d = 1'b1;
                cnt_d = STROBE_LAST;
            end
        end else if (setup_q) begin
            setup_d = 1'b0;
            act_d   = 1'b1;
            cnt_d   = STROBE_LAST;
        end else if (act_q) begin
            if (cnt_q == 4'd0) begin
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
        we_d = act_d ? grp_mask(grp_d) : 6'b000000;
    end

    // busy drops during the final strobe cycle so the caller reaches GAP as WE falls.
    assign busy_o = setup_q | (act_q & (cnt_q != 4'd0));

    assign WE_period_low  = we_q[0];
    assign WE_period_high = we_q[1];
    assign WE_impuls_low  = we_q[2];
    assign WE_impuls_high = we_q[3];
    assign WE_enable_pwm  = we_q[4];
    assign WE_disable_pwm = we_q[5];

endmodule

// File: rtl/pwm_cmd_decoder.sv
// Serial command decoder for the PWM stage: parses SYNC/CMD/LO/HI/CHK frames,
// loads the period/impuls buses and fires the matching write strobe.
module pwm_cmd_decoder
    import pwm_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic             Clock,
    input  logic             Reset,
    pwm_cmd_decoder_if.slave rx,
    output logic [7:0]       period_low,
    output logic [7:0]       period_high,
    output logic [7:0]       impuls_low,
    output logic [7:0]       impuls_high,
    output logic             WE_period_low,
    output logic             WE_period_high,
    output logic             WE_impuls_low,
    output logic             WE_impuls_high,
    output logic             WE_enable_pwm,
    output logic             WE_disable_pwm,
    output logic             frame_ok,
    output logic             frame_err
);

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d, lo_q, lo_d, hi_q, hi_d;
    logic [7:0]  period_low_q, period_low_d, period_high_q, period_high_d;
    logic [7:0]  impuls_low_q, impuls_low_d, impuls_high_q, impuls_high_d;
    logic [15:0] gap_q, gap_d;
    logic        armed_q;
    logic        frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic        accept, in_get, chk_good, timeout, start, sg_busy;
    strobe_grp_t grp;

    // armed_q keeps rx_ready low until the first edge after reset release.
    assign rx.rx_ready = armed_q && (state_q != ST_STROBE) && (state_q != ST_GAP);
    assign accept      = rx.rx_valid && rx.rx_ready;
    assign in_get      = (state_q == ST_GET_CMD) || (state_q == ST_GET_LO) ||
                         (state_q == ST_GET_HI)  || (state_q == ST_GET_CHK);
    assign chk_good    = (rx.rx_data == (cmd_q ^ lo_q ^ hi_q)) && cmd_is_valid(cmd_q);
    assign timeout     = in_get && !accept && (gap_q == TIMEOUT_VAL);
    assign grp         = cmd_to_grp(cmd_q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept && rx.rx_data == SYNC_BYTE) state_d = ST_GET_CMD;
            ST_GET_CMD: if (accept) state_d = ST_GET_LO;  else if (timeout) state_d = ST_IDLE;
            ST_GET_LO:  if (accept) state_d = ST_GET_HI;  else if (timeout) state_d = ST_IDLE;
            ST_GET_HI:  if (accept) state_d = ST_GET_CHK; else if (timeout) state_d = ST_IDLE;
            ST_GET_CHK: begin
                if (accept)       state_d = chk_good ? ST_STROBE : ST_IDLE;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_STROBE:  if (!sg_busy) state_d = ST_GAP;
            ST_GAP:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start         = (state_q == ST_GET_CHK) && accept && chk_good;
        frame_ok_d    = start;
        frame_err_d   = ((state_q == ST_GET_CHK) && accept && !chk_good) || timeout;
        gap_d         = (accept || !in_get || timeout) ? 16'd0 : gap_q + 16'd1;
        cmd_d         = cmd_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        period_low_d  = period_low_q;
        period_high_d = period_high_q;
        impuls_low_d  = impuls_low_q;
        impuls_high_d = impuls_high_q;
        if (accept) begin
            case (state_q)
                ST_GET_CMD: cmd_d = rx.rx_data;
                ST_GET_LO:  lo_d  = rx.rx_data;
                ST_GET_HI:  hi_d  = rx.rx_data;
                default: ;
            endcase
        end
        if (start && grp == GRP_PERIOD) begin
            period_low_d  = lo_q;
            period_high_d = hi_q;
        end
        if (start && grp == GRP_IMPULS) begin
            impuls_low_d  = lo_q;
            impuls_high_d = hi_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cmd_q         <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            period_low_q  <= '0;
            period_high_q <= '0;
            impuls_low_q  <= '0;
            impuls_high_q <= '0;
            gap_q         <= '0;
            armed_q       <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            cmd_q         <= cmd_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            period_low_q  <= period_low_d;
            period_high_q <= period_high_d;
            impuls_low_q  <= impuls_low_d;
            impuls_high_q <= impuls_high_d;
            gap_q         <= gap_d;
            armed_q       <= 1'b1;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
        end
    end

    pwm_strobe_gen #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_strobe_gen (
        .Clock          (Clock),
        .Reset          (Reset),
        .start_i        (start),
        .grp_i          (grp),
        .WE_period_low  (WE_period_low),
        .WE_period_high (WE_period_high),
        .WE_impuls_low  (WE_impuls_low),
        .WE_impuls_high (WE_impuls_high),
        .WE_enable_pwm  (WE_enable_pwm),
        .WE_disable_pwm (WE_disable_pwm),
        .busy_o         (sg_busy)
    );

    assign period_low  = period_low_q;
    assign period_high = period_high_q;
    assign impuls_low  = impuls_low_q;
    assign impuls_high = impuls_high_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pwm_cmd_decoder.sv
// Bench for pwm_cmd_decoder: directed and random frames, a frame-level reference
// model feeding an expectation queue, and a monitor that checks status and strobes.
module tb_pwm_cmd_decoder;

    localparam int         STROBE_N  = 2;
    localparam int         TIMEOUT_N = 1000;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] period_low, period_high, impuls_low, impuls_high;
    logic       WE_period_low, WE_period_high, WE_impuls_low, WE_impuls_high;
    logic       WE_enable_pwm, WE_disable_pwm, frame_ok, frame_err;

    pwm_cmd_decoder_if rx ();

    pwm_cmd_decoder #(
        .SYNC_BYTE      (SYNC),
        .STROBE_CYCLES  (STROBE_N),
        .TIMEOUT_CYCLES (TIMEOUT_N)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .rx             (rx),
        .period_low     (period_low),
        .period_high    (period_high),
        .impuls_low     (impuls_low),
        .impuls_high    (impuls_high),
        .WE_period_low  (WE_period_low),
        .WE_period_high (WE_period_high),
        .WE_impuls_low  (WE_impuls_low),
        .WE_impuls_high (WE_impuls_high),
        .WE_enable_pwm  (WE_enable_pwm),
        .WE_disable_pwm (WE_disable_pwm),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          ok;
        int          grp;
        logic [31:0] buses;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mdl_buf[$];
    logic [7:0] m_pl = 8'h00, m_ph = 8'h00, m_il = 8'h00, m_ih = 8'h00;
    int         checks = 0;
    int         failures = 0;

    function automatic logic [31:0] bus_vec();
        return {period_low, period_high, impuls_low, impuls_high};
    endfunction

    function automatic logic [31:0] strobe_vec();
        return 32'({WE_disable_pwm, WE_enable_pwm, WE_impuls_high,
                    WE_impuls_low, WE_period_high, WE_period_low});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: frames are found by content, independent of cycle timing.
    task automatic model_byte(input logic [7:0] b);
        exp_t       e;
        logic [7:0] cmd, lo, hi, chk;
        if (mdl_buf.size() == 0 && b != SYNC) return;
        mdl_buf.push_back(b);
        if (mdl_buf.size() < 5) return;
        cmd = mdl_buf[1]; lo = mdl_buf[2]; hi = mdl_buf[3]; chk = mdl_buf[4];
        mdl_buf.delete();
        e.ok  = (chk == (cmd ^ lo ^ hi)) && cmd >= 8'd1 && cmd <= 8'd4;
        e.grp = int'(cmd) - 1;
        if (e.ok && cmd == 8'd1) begin m_pl = lo; m_ph = hi; end
        if (e.ok && cmd == 8'd2) begin m_il = lo; m_ih = hi; end
        e.buses = {m_pl, m_ph, m_il, m_ih};
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, output int stalls);
        bit got;
        stalls = 0;
        got = 0;
        rx.rx_data  = b;
        rx.rx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clock);
            if (rx.rx_ready) begin got = 1; break; end
            stalls++;
        end
        if (!got) check("rx_ready_wait", 32'(rx.rx_ready), 32'd1);
        @(posedge Clock);
        #1;
        rx.rx_valid = 1'b0;
        if (got) model_byte(b);
    endtask

    task automatic idle(input int n);
        rx.rx_valid = 1'b0;
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic send5(input logic [7:0] b0, b1, b2, b3, b4, input int max_gap);
        logic [7:0] f[5];
        int         st;
        f = '{b0, b1, b2, b3, b4};
        foreach (f[i]) begin
            send_byte(f[i], st);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic send_random_frame(input bit force_good);
        int         kind, st;
        logic [7:0] cmd, lo, hi, chk, junk;
        kind = force_good ? 0 : $urandom_range(0, 9);
        cmd  = 8'($urandom_range(1, 4));
        lo   = 8'($urandom);
        hi   = 8'($urandom);
        if ($urandom_range(0, 5) == 0) lo = SYNC;
        if ($urandom_range(0, 5) == 0) hi = SYNC;
        if (kind == 8) cmd = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(5, 255));
        chk = cmd ^ lo ^ hi;
        if (kind == 7) chk = chk ^ (8'h01 << $urandom_range(0, 7));
        if (kind == 9) begin
            junk = 8'($urandom);
            if (junk == SYNC) junk = 8'h00;
            send_byte(junk, st);
        end
        send5(SYNC, cmd, lo, hi, chk, 3);
        idle($urandom_range(0, 4));
    endtask

    // Monitor: pops one expectation per status pulse and follows the strobe run after it.
    int         cyc = 0, ok_cyc = 0, pend_grp = -1, run_len = 0, g = -1;
    logic [5:0] s;
    exp_t       cur;

    always @(negedge Clock) begin
        cyc++;
        if (!Reset) begin
            run_len  = 0;
            pend_grp = -1;
        end else begin
            if (frame_ok || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("status_unexpected", 32'({frame_ok, frame_err}), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("status_kind", 32'({frame_ok, frame_err}), cur.ok ? 32'd2 : 32'd1);
                    check("buses_at_status", bus_vec(), cur.buses);
                    if (frame_ok) begin
                        pend_grp = cur.grp;
                        ok_cyc   = cyc;
                    end
                end
            end
            s = 6'(strobe_vec());
            g = -1;
            if (s[1:0] != 2'b00)      g = 0;
            else if (s[3:2] != 2'b00) g = 1;
            else if (s[4])            g = 2;
            else if (s[5])            g = 3;
            if (g >= 0) begin
                check("strobe_shape", 32'(s),
                      (g == 0) ? 32'h03 : (g == 1) ? 32'h0C : (g == 2) ? 32'h10 : 32'h20);
                if (run_len == 0) begin
                    check("strobe_group", 32'(g), 32'(pend_grp));
                    check("strobe_delay", 32'(cyc - ok_cyc), (pend_grp < 2) ? 32'd1 : 32'd0);
                end
                run_len++;
            end else if (run_len > 0) begin
                check("strobe_len", 32'(run_len), 32'(STROBE_N));
                check("buses_after_strobe", bus_vec(), cur.buses);
                run_len  = 0;
                pend_grp = -1;
            end
        end
    end

    initial begin
        int st, n;
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        repeat (3) @(negedge Clock);
        check("reset_ready", 32'(rx.rx_ready), 32'd0);
        check("reset_buses", bus_vec(), 32'd0);
        check("reset_strobes", strobe_vec(), 32'd0);
        check("reset_status", 32'({frame_ok, frame_err}), 32'd0);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("ready_after_release", 32'(rx.rx_ready), 32'd1);

        send5(8'hA5, 8'h01, 8'hE8, 8'h03, 8'hEA, 0);
        idle(5);
        send5(8'hA5, 8'h02, 8'hF4, 8'h01, 8'hF7, 0);
        idle(5);
        send5(8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 0);
        send5(8'hA5, 8'h02, 8'h11, 8'h22, 8'h31, 0);
        idle(5);

        send_byte(8'h33, st);
        send5(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03, 0);
        send_byte(8'h11, st);
        check("ready_low_cycles", 32'(st), 32'd3);
        idle(5);

        send_byte(SYNC, st);
        send_byte(8'h04, st);
        mdl_buf.delete();
        exp_q.push_back('{ok: 1'b0, grp: 0, buses: {m_pl, m_ph, m_il, m_ih}});
        n = 0;
        for (int k = 1; k <= TIMEOUT_N + 50; k++) begin
            @(negedge Clock);
            if (frame_err) begin n = k; break; end
        end
        check("timeout_cycle", 32'(n), 32'(TIMEOUT_N + 2));
        #1;
        idle(2);
        send_random_frame(1'b1);

        for (int i = 0; i < 80; i++) send_random_frame(1'b0);
        idle(10);

        send5(SYNC, 8'h01, 8'h5A, 8'hC3, 8'h01 ^ 8'h5A ^ 8'hC3, 0);
        for (int k = 0; k < 20 && !WE_period_low; k++) @(negedge Clock);
        check("reset_test_strobe_seen", 32'(WE_period_low), 32'd1);
        #1 Reset = 1'b0;
        #1;
        check("midstrobe_reset_strobes", strobe_vec(), 32'd0);
        check("midstrobe_reset_buses", bus_vec(), 32'd0);
        check("midstrobe_reset_ready", 32'(rx.rx_ready), 32'd0);
        m_pl = 8'h00; m_ph = 8'h00; m_il = 8'h00; m_ih = 8'h00;
        mdl_buf.delete();
        exp_q.delete();
        repeat (2) @(negedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("ready_after_midstrobe_reset", 32'(rx.rx_ready), 32'd1);
        send_random_frame(1'b1);
        send_random_frame(1'b1);

        idle(12);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
